alu_mc: RTL and testbench

Parametrised, multi-cycle successor to the 8-bit combinational ALU. It keeps the same 16-entry fsl opcode map and the same {OVERFLOW, SIGN, CARRY, ZERO} status layout. New in this block: a registered status register, so ADDC/SUBC chain through a stored carry; a valid/ready handshake on input and output; and an iterative shift-add multiplier. It sits between the operand/decode stage and the writeback stage of the datapath.

---
 rtl/alu_mc.sv | 195 +++++++++++++++++++
 tb/tb_alu_mc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 16-op fsl map, registered {V,N,C,Z} status, valid/ready handshake.
// Build the iterative shift-add multiplier by defining ALU_MC_MUL_EN.
module alu_mc #(
    parameter int WIDTH     = 8,
    parameter int MUL_CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       fsl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mul_high,
    output logic [3:0]       SREG
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_ADDC = 4'h2, OP_SUBC = 4'h3,
        OP_XOR  = 4'h4, OP_AND  = 4'h5, OP_OR   = 4'h6, OP_NAND = 4'h7,
        OP_LSL  = 4'h8, OP_LSR  = 4'h9, OP_ASL  = 4'hA, OP_ASR  = 4'hB,
        OP_ROL  = 4'hC, OP_ROR  = 4'hD, OP_MUL  = 4'hE, OP_CMP  = 4'hF
    } op_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_mul_high;
    logic [3:0]       r_sreg;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_last;
    logic             w_cin;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_keep;
    logic [3:0]       w_sreg;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign mul_high  = r_mul_high;
    assign SREG      = r_sreg;
    assign w_accept  = in_valid && in_ready;

    // Single-cycle ops are evaluated straight from the inputs on the accept edge.
    always_comb begin
        w_cin  = ((fsl == OP_ADDC) || (fsl == OP_SUBC)) ? r_sreg[1] : 1'b0;
        w_add  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, w_cin};
        w_sub  = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, w_cin};
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_keep = 1'b0;
        case (op_e'(fsl))
            OP_ADD, OP_ADDC: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (A[MSB] == B[MSB]) && (w_add[MSB] != A[MSB]);
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                w_res  = w_sub[WIDTH-1:0];
                w_c    = w_sub[WIDTH];
                w_v    = (A[MSB] != B[MSB]) && (w_sub[MSB] != A[MSB]);
                w_keep = (fsl == OP_CMP);
            end
            OP_XOR:  w_res = A ^ B;
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_NAND: w_res = ~(A & B);
            OP_LSL: begin
                w_res = {A[MSB-1:0], 1'b0};
                w_c   = A[MSB];
            end
            OP_LSR: begin
                w_res = {1'b0, A[MSB:1]};
                w_c   = A[0];
            end
            OP_ASL: begin
                w_res = {A[MSB-1:0], 1'b0};
                w_c   = A[MSB];
                w_v   = A[MSB] ^ A[MSB-1];
            end
            OP_ASR: begin
                w_res = {A[MSB], A[MSB:1]};
                w_c   = A[0];
            end
            OP_ROL: begin
                w_res = {A[MSB-1:0], A[MSB]};
                w_c   = A[MSB];
            end
            OP_ROR: begin
                w_res = {A[0], A[MSB:1]};
                w_c   = A[0];
            end
            OP_MUL:  w_res = '0;
        endcase
        w_sreg = {w_v, w_res[MSB], w_c, (w_res == '0)};
    end

`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0]     r_ma;
    logic [WIDTH-1:0]     r_mhi;
    logic [WIDTH-1:0]     r_mlo;
    logic [MUL_CNT_W-1:0] r_cnt;
    logic [WIDTH:0]       w_mstep;
    logic [WIDTH-1:0]     w_mhi_nxt;
    logic [WIDTH-1:0]     w_mlo_nxt;

    // {hi,lo} starts as {0,B}; each step adds A into hi when lo[0] is set, then shifts right.
    always_comb begin
        w_mstep    = {1'b0, r_mhi} + (r_mlo[0] ? {1'b0, r_ma} : '0);
        w_mhi_nxt  = w_mstep[WIDTH:1];
        w_mlo_nxt  = {w_mstep[0], r_mlo[WIDTH-1:1]};
        w_mul_last = (r_cnt == MUL_CNT_W'(WIDTH - 1));
        w_is_mul   = (fsl == OP_MUL);
    end
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_last = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
            S_MUL:  if (w_mul_last) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= '0;
            r_mul_high <= '0;
            r_sreg     <= '0;
`ifdef ALU_MC_MUL_EN
            r_ma       <= '0;
            r_mhi      <= '0;
            r_mlo      <= '0;
            r_cnt      <= '0;
`endif
        end else begin
            if (w_accept && !w_is_mul) begin
                if (!w_keep) r_result <= w_res;
                r_mul_high <= '0;
                r_sreg     <= w_sreg;
            end
`ifdef ALU_MC_MUL_EN
            if (w_accept && w_is_mul) begin
                r_ma  <= A;
                r_mhi <= '0;
                r_mlo <= B;
                r_cnt <= '0;
            end
            if (r_state == S_MUL) begin
                r_mhi <= w_mhi_nxt;
                r_mlo <= w_mlo_nxt;
                r_cnt <= r_cnt + MUL_CNT_W'(1);
                if (w_mul_last) begin
                    r_result   <= w_mlo_nxt;
                    r_mul_high <= w_mhi_nxt;
                    r_sreg     <= {1'b0, w_mhi_nxt[MSB], (w_mhi_nxt != '0),
                                   ({w_mhi_nxt, w_mlo_nxt} == '0)};
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=8); follows ALU_MC_MUL_EN for MUL expectations.
module tb_alu_mc;

    localparam int W = 8;
`ifdef ALU_MC_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   fsl;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] mul_high;
    logic [3:0]   SREG;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fsl(fsl), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .mul_high(mul_high), .SREG(SREG)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic [3:0] sreg;
        logic [7:0] lat;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_res;
    logic       m_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic [7:0] h,
                                input logic [3:0] s, input int lat);
        exp_t e;
        e.res  = r;
        e.hi   = h;
        e.sreg = s;
        e.lat  = 8'(lat);
        return e;
    endfunction

    // Reference model in plain integer arithmetic; tracks stored carry and last result.
    function automatic exp_t model(input logic [3:0] f, input int a, input int b);
        exp_t e;
        int   sa, sbv, cin, s, r, p;
        logic c, v;
        sa  = (a > 127) ? a - 256 : a;
        sbv = (b > 127) ? b - 256 : b;
        cin = ((f == 4'h2) || (f == 4'h3)) ? int'(m_c) : 0;
        c = 1'b0; v = 1'b0; r = 0;
        e = mk(8'h00, 8'h00, 4'h0, 1);
        case (f)
            4'h0, 4'h2: begin
                s = a + b + cin; r = s & 255; c = (s > 255);
                v = ((sa + sbv + cin) > 127) || ((sa + sbv + cin) < -128);
            end
            4'h1, 4'h3, 4'hF: begin
                s = a - b - cin; r = s & 255; c = (s < 0);
                v = ((sa - sbv - cin) > 127) || ((sa - sbv - cin) < -128);
            end
            4'h4: r = a ^ b;
            4'h5: r = a & b;
            4'h6: r = a | b;
            4'h7: r = (~(a & b)) & 255;
            4'h8: begin r = (a << 1) & 255; c = ((a >> 7) & 1) == 1; end
            4'h9: begin r = a >> 1; c = (a & 1) == 1; end
            4'hA: begin
                r = (a << 1) & 255; c = ((a >> 7) & 1) == 1;
                v = ((a >> 7) & 1) != ((a >> 6) & 1);
            end
            4'hB: begin r = (a >> 1) | (a & 128); c = (a & 1) == 1; end
            4'hC: begin r = ((a << 1) | (a >> 7)) & 255; c = ((a >> 7) & 1) == 1; end
            4'hD: begin r = (a >> 1) | ((a & 1) << 7); c = (a & 1) == 1; end
            default: r = 0;
        endcase
        if (f == 4'hE && MUL_ON) begin
            p      = a * b;
            e.res  = 8'(p & 255);
            e.hi   = 8'(p >> 8);
            e.sreg = {1'b0, ((p >> 15) & 1) == 1, (p >> 8) != 0, p == 0};
            e.lat  = 8'(W + 1);
        end else begin
            e.res  = (f == 4'hF) ? m_res : 8'(r);
            e.sreg = {v, (r & 128) != 0, c, r == 0};
        end
        return e;
    endfunction

    task automatic run_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                          input exp_t e, input int hold);
        int   lat;
        exp_t x;
        chk("in_ready_idle", in_ready, 1);
        fsl = f; A = a; B = b; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            chk("in_ready_busy", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid", out_valid, 1);
        chk("latency", lat, e.lat);
        x = sb.pop_front();
        chk("result", result, x.res);
        chk("mul_high", mul_high, x.hi);
        chk("sreg", SREG, x.sreg);
        m_res = x.res;
        m_c   = x.sreg[1];
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid = 1'b1; fsl = ~f; A = ~a; B = a;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("bp_valid", out_valid, 1);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_result", result, x.res);
                chk("bp_hi", mul_high, x.hi);
                chk("bp_sreg", SREG, x.sreg);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("out_valid_drop", out_valid, 0);
    endtask

    task automatic run_model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        run_op(f, a, b, model(f, int'(a), int'(b)), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        fsl = 4'h0; A = '0; B = '0;
        m_res = '0; m_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 0);
        chk("rst_hi", mul_high, 0);
        chk("rst_sreg", SREG, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(4'h0, 8'h7F, 8'h01, mk(8'h80, 8'h00, 4'b1100, 1), 0);
        run_op(4'h1, 8'h10, 8'h20, mk(8'hF0, 8'h00, 4'b0110, 1), 0);
        run_op(4'h2, 8'h01, 8'h01, mk(8'h03, 8'h00, 4'b0000, 1), 0);
        if (MUL_ON) run_op(4'hE, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 4'b0110, W + 1), 0);
        else        run_op(4'hE, 8'hFF, 8'hFF, mk(8'h00, 8'h00, 4'b0001, 1), 0);
        run_op(4'h8, 8'h81, 8'h00, mk(8'h02, 8'h00, 4'b0010, 1), 0);
        run_op(4'hB, 8'h81, 8'h00, mk(8'hC0, 8'h00, 4'b0110, 1), 0);
        run_op(4'hD, 8'h81, 8'h00, mk(8'hC0, 8'h00, 4'b0110, 1), 0);
        run_op(4'hA, 8'h81, 8'h00, mk(8'h02, 8'h00, 4'b1010, 1), 0);
        run_op(4'h0, 8'h7F, 8'h01, mk(8'h80, 8'h00, 4'b1100, 1), 0);
        run_op(4'hF, 8'h42, 8'h42, mk(8'h80, 8'h00, 4'b0001, 1), 0);

        // Backpressure with in_valid asserted throughout, then an op proving nothing slipped in.
        run_op(4'h4, 8'hF0, 8'h0F, mk(8'hFF, 8'h00, 4'b0100, 1), 5);
        run_op(4'h0, 8'h01, 8'h02, mk(8'h03, 8'h00, 4'b0000, 1), 0);

        // Reset in the middle of a multiply (or a held result without the multiplier).
        run_op(4'h1, 8'h00, 8'h01, mk(8'hFF, 8'h00, 4'b0110, 1), 0);
        fsl = 4'hE; A = 8'h03; B = 8'h05; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_result", result, 0);
        chk("mrst_hi", mul_high, 0);
        chk("mrst_sreg", SREG, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        m_res = '0; m_c = 1'b0;
        @(posedge clk); #1;
        run_model(4'h2, 8'h10, 8'h20);
        run_model(4'hE, 8'h0D, 8'h0B);

        for (int i = 0; i < 24; i++) begin
            run_model(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
